// File: rtl/gpu_prim_receiver.sv
// -----------------------------------------------------------------------------
// gpu_prim_receiver
//
// Receiving end of the writeback->GPU primitive interface. Each cycle the
// writeback stage presents a valid GSR value (with I_LOCK high), the GSR value
// and its three vertices are captured into a small FIFO. Entries are issued
// one at a time to the rasterizer over a valid/ready handshake. A registered
// stall signal throttles writeback, keeping one entry of headroom so that the
// one-cycle reaction latency of writeback does not overflow the FIFO.
//
// Optional feature (compile-time macro GPU_CULL_DEGENERATE_EN):
//   When defined, an entry whose vertices are not all distinct is discarded
//   at pop time instead of being issued, and O_CullCount counts it.
//   When undefined, every entry is issued and O_CullCount is tied to 0.
// -----------------------------------------------------------------------------
module gpu_prim_receiver #(
  parameter int GSR_W      = 32,
  parameter int VERTEX_W   = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET_N,
  input  logic                I_LOCK,
  input  logic [GSR_W-1:0]    I_GSRValue,
  input  logic                I_GSRValue_Valid,
  input  logic [VERTEX_W-1:0] I_VertexV1,
  input  logic [VERTEX_W-1:0] I_VertexV2,
  input  logic [VERTEX_W-1:0] I_VertexV3,
  input  logic                I_RasterReady,
  output logic                O_GPUStallSignal,
  output logic                O_PrimValid,
  output logic [GSR_W-1:0]    O_PrimGSR,
  output logic [VERTEX_W-1:0] O_PrimV1,
  output logic [VERTEX_W-1:0] O_PrimV2,
  output logic [VERTEX_W-1:0] O_PrimV3,
  output logic [7:0]          O_DropCount,
  output logic [7:0]          O_CullCount,
  output logic                O_Busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(FIFO_DEPTH - 1);

  // One buffered primitive: GSR value plus its three vertices.
  typedef struct packed {
    logic [GSR_W-1:0]    gsr;
    logic [VERTEX_W-1:0] v1;
    logic [VERTEX_W-1:0] v2;
    logic [VERTEX_W-1:0] v3;
  } prim_t;

  // IDLE: nothing presented. ISSUE: O_Prim* held for the rasterizer.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping
  // ---------------------------------------------------------------------------
  prim_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  state_t           state;
  logic [7:0]       drop_cnt;

  prim_t entry_in;
  prim_t head;
  logic  fifo_full;
  logic  fifo_empty;
  logic  capture;
  logic  push;
  logic  drop;
  logic  pop;
  logic  degenerate;

  assign entry_in = '{gsr: I_GSRValue, v1: I_VertexV1, v2: I_VertexV2, v3: I_VertexV3};
  assign head     = mem[rd_ptr];

  // Full/empty are judged on the count at the start of the cycle, so a pop
  // in the same cycle never makes room for a push into a full FIFO.
  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  // A capture request is only honoured while the pipeline is enabled.
  assign capture = I_LOCK & I_GSRValue_Valid;
  assign push    = capture & ~fifo_full;
  assign drop    = capture & fifo_full;

  // The head leaves the FIFO whenever the output slot is free or is being
  // freed by a handshake this cycle; this gives back-to-back issue.
  assign pop = ~fifo_empty & ((state == IDLE) | I_RasterReady);

`ifdef GPU_CULL_DEGENERATE_EN
  // A primitive with any two coincident vertices has zero area.
  assign degenerate = (head.v1 == head.v2) | (head.v2 == head.v3) | (head.v1 == head.v3);
`else
  assign degenerate = 1'b0;
`endif

  // Occupancy after this cycle's push/pop, used for count and stall.
  always_comb begin
    // NOTE: default assignment first so every path drives count_next and no latch is inferred.
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO data array write on accepted capture.
  // NOTE: the data array has no reset; the count and pointers alone decide which entries are live.
  always_ff @(posedge I_CLOCK) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge I_CLOCK) begin
    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    if (!I_RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Registered throttle to writeback and saturating overflow counter.
  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      O_GPUStallSignal <= 1'b0;
      drop_cnt         <= '0;
    end else begin
      O_GPUStallSignal <= (count_next >= CNT_STALL);
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign O_DropCount = drop_cnt;

  // Issue FSM: loads the popped head into the output registers and holds it
  // until the rasterizer accepts it. A culled head leaves the slot empty.
  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state       <= IDLE;
      O_PrimValid <= 1'b0;
      O_PrimGSR   <= '0;
      O_PrimV1    <= '0;
      O_PrimV2    <= '0;
      O_PrimV3    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop && !degenerate) begin
            state       <= ISSUE;
            O_PrimValid <= 1'b1;
            O_PrimGSR   <= head.gsr;
            O_PrimV1    <= head.v1;
            O_PrimV2    <= head.v2;
            O_PrimV3    <= head.v3;
          end
        end
        ISSUE: begin
          if (I_RasterReady) begin
            if (pop && !degenerate) begin
              O_PrimGSR <= head.gsr;
              O_PrimV1  <= head.v1;
              O_PrimV2  <= head.v2;
              O_PrimV3  <= head.v3;
            end else begin
              state       <= IDLE;
              O_PrimValid <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          O_PrimValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef GPU_CULL_DEGENERATE_EN
  logic [7:0] cull_cnt;

  // Saturating count of primitives discarded at pop for zero area.
  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      cull_cnt <= '0;
    end else if (pop && degenerate && (cull_cnt != 8'hFF)) begin
      cull_cnt <= cull_cnt + 8'd1;
    end
  end

  assign O_CullCount = cull_cnt;
`else
  assign O_CullCount = '0;
`endif

  // Activity indicator for power/idle detection upstream.
  assign O_Busy = (count != '0) | O_PrimValid;

endmodule
